// File: rtl/wb_pkg.sv
// Write-back commit shared types and sizing.
// Optional load bypass: WB_LOAD_BYPASS_EN.
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 2 ** REG_ADDR_W;
  localparam int LQ_DEPTH   = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       dat;
  } wb_entry_t;
endpackage

// File: rtl/wb_load_fifo.sv
// Load response queue for the write-back port.
// Pointers carry one extra wrap bit to tell full from empty.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = LQ_DEPTH
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      push_i,
  input  wb_entry_t entry_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic        do_push;
  logic        do_pop;
  wb_entry_t   mem_q [DEPTH];

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rp_q[AW-1:0]];

  always_comb begin
    wp_d = wp_q + {{AW{1'b0}}, do_push};
    rp_d = rp_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= entry_i;
  end
endmodule

// File: rtl/wb_commit.sv
// Register-file write port arbiter: ALU first, then queued loads.
// Define WB_LOAD_BYPASS_EN to let a load skip an empty queue.
module wb_commit
  import wb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_dat_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]       lsu_dat_i,
  input  logic                  iss_load_i,
  input  logic [REG_ADDR_W-1:0] iss_rd_i,
  output logic [NREG-1:0]       busy_o,
  output logic                  wr_en_o,
  output logic [REG_ADDR_W-1:0] reg_des_o,
  output logic [XLEN-1:0]       reg_des_dat_o
);
  logic            full, empty;
  logic            alu_fire, lsu_fire;
  logic            byp, push, pop;
  logic            cm_vld, cm_ld;
  wb_entry_t       cm, head;
  logic            wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] dat_q, dat_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign alu_ready_o   = !full;
  assign lsu_ready_o   = !full;
  assign busy_o        = busy_q;
  assign wr_en_o       = wr_en_q;
  assign reg_des_o     = rd_q;
  assign reg_des_dat_o = dat_q;

  wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .entry_i ('{rd: lsu_rd_i, dat: lsu_dat_i}),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    alu_fire = alu_valid_i && !full;
    lsu_fire = lsu_valid_i && !full;
`ifdef WB_LOAD_BYPASS_EN
    byp      = lsu_fire && empty && !alu_fire;
`else
    byp      = 1'b0;
`endif
    push     = lsu_fire && !byp;
    pop      = !alu_fire && !empty;
  end

  always_comb begin
    cm_vld = 1'b0;
    cm_ld  = 1'b0;
    cm     = '0;
    unique case (1'b1)
      alu_fire: begin
        cm_vld = 1'b1;
        cm     = '{rd: alu_rd_i, dat: alu_dat_i};
      end
      pop: begin
        cm_vld = 1'b1;
        cm_ld  = 1'b1;
        cm     = head;
      end
      byp: begin
        cm_vld = 1'b1;
        cm_ld  = 1'b1;
        cm     = '{rd: lsu_rd_i, dat: lsu_dat_i};
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_en_d = cm_vld && (cm.rd != '0);
    rd_d    = cm_vld ? cm.rd : rd_q;
    dat_d   = cm_vld ? cm.dat : dat_q;
    busy_d  = busy_q;
    if (cm_ld) busy_d[cm.rd] = 1'b0;
    // A new issue to the same rd outranks the clear.
    if (iss_load_i) busy_d[iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      dat_q   <= '0;
      busy_q  <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      rd_q    <= rd_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit with a commit scoreboard.
module tb_wb_commit;
  import wb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  alu_valid = 1'b0;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd = '0;
  logic [XLEN-1:0]       alu_dat = '0;
  logic                  lsu_valid = 1'b0;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd = '0;
  logic [XLEN-1:0]       lsu_dat = '0;
  logic                  iss_load = 1'b0;
  logic [REG_ADDR_W-1:0] iss_rd = '0;
  logic [NREG-1:0]       busy;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] reg_des;
  logic [XLEN-1:0]       reg_dat;

  int tests = 0;
  int fails = 0;

  wb_entry_t ld_q[$];
  logic      alu_pend = 1'b0;
  wb_entry_t alu_exp = '0;

  always #5 clk = ~clk;

  wb_commit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .alu_valid_i   (alu_valid),
    .alu_ready_o   (alu_ready),
    .alu_rd_i      (alu_rd),
    .alu_dat_i     (alu_dat),
    .lsu_valid_i   (lsu_valid),
    .lsu_ready_o   (lsu_ready),
    .lsu_rd_i      (lsu_rd),
    .lsu_dat_i     (lsu_dat),
    .iss_load_i    (iss_load),
    .iss_rd_i      (iss_rd),
    .busy_o        (busy),
    .wr_en_o       (wr_en),
    .reg_des_o     (reg_des),
    .reg_des_dat_o (reg_dat)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record what the upcoming edge should accept, then advance one cycle.
  task automatic step();
    if (alu_valid && alu_ready) begin
      alu_pend = 1'b1;
      alu_exp  = '{rd: alu_rd, dat: alu_dat};
    end
    if (lsu_valid && lsu_ready && lsu_rd != '0)
      ld_q.push_back('{rd: lsu_rd, dat: lsu_dat});
    @(negedge clk);
  endtask

  // ALU transfers commit on the next edge; any other write must be a load.
  always @(posedge clk) begin
    logic      pend;
    wb_entry_t e;
    wb_entry_t l;
    pend     = alu_pend;
    e        = alu_exp;
    alu_pend = 1'b0;
    #2;
    if (pend) begin
      chk("alu_wr_en", wr_en, e.rd != '0);
      if (e.rd != '0) begin
        chk("alu_rd", reg_des, e.rd);
        chk("alu_dat", reg_dat, e.dat);
      end
    end else if (wr_en === 1'b1) begin
      tests++;
      assert (ld_q.size() > 0) else begin
        fails++;
        $error("FAIL stray_commit observed rd=%0d expected=none", reg_des);
      end
      if (ld_q.size() > 0) begin
        l = ld_q.pop_front();
        chk("ld_rd", reg_des, l.rd);
        chk("ld_dat", reg_dat, l.dat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int lk;
    int an;
    logic a_ok, l_ok;
    logic [NREG-1:0] b;

    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_rdy", alu_ready, 1);
    chk("rst_lsu_rdy", lsu_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ALU result
    alu_valid = 1'b1; alu_rd = 5; alu_dat = 32'h1234;
    step();
    alu_valid = 1'b0;
    chk("alu_latency", wr_en, 1);
    step();

    // Load scoreboard set and clear
    iss_load = 1'b1; iss_rd = 7;
    step();
    iss_load = 1'b0;
    chk("busy7_set", busy[7], 1);
    lsu_valid = 1'b1; lsu_rd = 7; lsu_dat = 32'hCAFE;
    step();
    lsu_valid = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
    chk("ld_lat_byp", wr_en, 1);
    chk("busy7_clr", busy[7], 0);
`else
    chk("ld_lat_n1", wr_en, 0);
    chk("busy7_hold", busy[7], 1);
    step();
    chk("ld_lat_n2", wr_en, 1);
    chk("busy7_clr", busy[7], 0);
`endif
    step();

    // ALU every cycle while five loads arrive
    an = 0; lk = 1;
    alu_valid = 1'b1; alu_rd = 20; alu_dat = 32'hA000_0000;
    lsu_valid = 1'b1; lsu_rd = 1; lsu_dat = 32'h1000_0001;
    for (int i = 0; i < 4; i++) begin
      chk("fill_lsu_rdy", lsu_ready, 1);
      chk("fill_alu_rdy", alu_ready, 1);
      step();
      an++; alu_rd = REG_ADDR_W'(20 + an % 8); alu_dat = 32'hA000_0000 + an;
      lk++; lsu_rd = REG_ADDR_W'(lk); lsu_dat = 32'h1000_0000 + lk;
    end
    chk("full_lsu_rdy", lsu_ready, 0);
    chk("full_alu_rdy", alu_ready, 0);
    step();
    chk("alu_rdy_back", alu_ready, 1);
    for (int c = 0; c < 30 && lk <= 5; c++) begin
      a_ok = alu_ready; l_ok = lsu_ready;
      step();
      if (a_ok) begin
        an++; alu_rd = REG_ADDR_W'(20 + an % 8); alu_dat = 32'hA000_0000 + an;
      end
      if (l_ok) begin
        lk++; lsu_rd = REG_ADDR_W'(lk); lsu_dat = 32'h1000_0000 + lk;
      end
    end
    lsu_valid = 1'b0;
    alu_valid = 1'b0;
    chk("all_loads_accepted", lk, 6);
    for (int c = 0; c < 40 && ld_q.size() > 0; c++) step();
    chk("loads_drained", ld_q.size(), 0);
    step();

    // x0 destinations
    alu_valid = 1'b1; alu_rd = 0; alu_dat = 32'h55;
    step();
    alu_valid = 1'b0;
    chk("alu_x0", wr_en, 0);
    lsu_valid = 1'b1; lsu_rd = 0; lsu_dat = 32'h77;
    step();
    lsu_valid = 1'b0;
    step();
    chk("ld_x0", wr_en, 0);
    step();
    chk("ld_x0_late", wr_en, 0);
    b = busy;
    iss_load = 1'b1; iss_rd = 0;
    step();
    iss_load = 1'b0;
    chk("iss_x0", busy, b);

    // Same-cycle set and clear on rd 9
    iss_load = 1'b1; iss_rd = 9;
    step();
    iss_load = 1'b0;
    chk("busy9_set", busy[9], 1);
    lsu_valid = 1'b1; lsu_rd = 9; lsu_dat = 32'h9999;
`ifdef WB_LOAD_BYPASS_EN
    iss_load = 1'b1;
    step();
    lsu_valid = 1'b0; iss_load = 1'b0;
`else
    step();
    lsu_valid = 1'b0;
    iss_load = 1'b1;
    step();
    iss_load = 1'b0;
`endif
    chk("rd9_commit", wr_en, 1);
    chk("busy9_set_wins", busy[9], 1);
    lsu_valid = 1'b1; lsu_dat = 32'h9A9A;
    step();
    lsu_valid = 1'b0;
    step();
    step();
    chk("busy9_clr", busy[9], 0);

    // Reset with three loads held in the queue
    alu_valid = 1'b1; alu_rd = 21; alu_dat = 32'hB000_0000;
    for (int k = 0; k < 3; k++) begin
      lsu_valid = 1'b1; lsu_rd = REG_ADDR_W'(11 + k);
      lsu_dat = 32'h2000_0000 + k;
      iss_load = 1'b1; iss_rd = REG_ADDR_W'(14 + k);
      step();
      alu_dat = alu_dat + 1;
    end
    rst_n = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0; iss_load = 1'b0;
    alu_pend = 1'b0;
    ld_q.delete();
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_rd", reg_des, 0);
    chk("mid_rst_dat", reg_dat, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", {alu_ready, lsu_ready}, 2'b11);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("post_rst_quiet", wr_en, 0);
    end
    chk("post_rst_rdy", lsu_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
